// File: rtl/mas_pkg.sv
// Shared definitions for the micro-address sequencer.
//   - Next-address opcodes carried in the microinstruction word.
//   - depth_w(): width needed to count 0..depth stack entries.
package mas_pkg;

  localparam logic [2:0] OP_INC     = 3'b000;
  localparam logic [2:0] OP_JMP     = 3'b001;
  localparam logic [2:0] OP_BRC     = 3'b010;
  localparam logic [2:0] OP_CALL    = 3'b011;
  localparam logic [2:0] OP_RET     = 3'b100;
  localparam logic [2:0] OP_HOLD    = 3'b101;
  localparam logic [2:0] OP_CALLC   = 3'b110;
  localparam logic [2:0] OP_RESTART = 3'b111;

  function automatic int depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mas_stack.sv
// Return-address LIFO for the micro-address sequencer.
// Ports:
//   i_clk    clock, state updates on the falling edge
//   i_rst_n  asynchronous active-low reset (empties the stack)
//   i_push   push i_din (ignored when full)
//   i_pop    drop top entry (ignored when empty)
//   i_clear  empty the stack (wins over push/pop)
//   i_din    value to push
//   o_dout   current top entry, combinational ('0 when empty)
//   o_depth  occupancy 0..STACK_DEPTH
//   o_full / o_empty  occupancy status
module mas_stack
  import mas_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic                             i_clear,
  input  logic [ADDR_WIDTH-1:0]            i_din,
  output logic [ADDR_WIDTH-1:0]            o_dout,
  output logic [depth_w(STACK_DEPTH)-1:0]  o_depth,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int DW = depth_w(STACK_DEPTH);
  // Index width kept >= 1 so a single-entry stack still elaborates.
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] r_mem [STACK_DEPTH];
  logic [DW-1:0]         r_depth;
  logic [IW-1:0]         w_wr_idx;
  logic [IW-1:0]         w_top_idx;

  assign o_full    = (r_depth == DW'(STACK_DEPTH));
  assign o_empty   = (r_depth == '0);
  assign o_depth   = r_depth;
  assign w_wr_idx  = IW'(r_depth);
  assign w_top_idx = IW'(r_depth - 1'b1);
  assign o_dout    = o_empty ? '0 : r_mem[w_top_idx];

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_depth <= '0;
    else if (i_clear)            r_depth <= '0;
    else if (i_push && !o_full)  r_depth <= r_depth + 1'b1;
    else if (i_pop && !o_empty)  r_depth <= r_depth - 1'b1;
  end

  // Contents need no reset: only entries below r_depth are ever read.
  always_ff @(negedge i_clk) begin
    if (!i_clear && i_push && !o_full) r_mem[w_wr_idx] <= i_din;
  end

endmodule

// File: rtl/micro_addr_sequencer.sv
// Micro-address sequencer: holds the current control-store address and
// selects the next one (inc / jump / cond branch / call / return / hold /
// restart) from the current microinstruction.
// Ports:
//   MAS_CLOCK_50        clock, state updates on the falling edge
//   MAS_RESET_InLow     asynchronous active-low reset
//   MAS_Enable_In       advance enable (low = full hold)
//   MAS_Op_In           next-address opcode
//   MAS_Target_In       jump/branch/call target
//   MAS_CondSel_In      condition flag index
//   MAS_CondPol_In      1 = branch on flag set, 0 = on flag clear
//   MAS_Cond_In         datapath status flags
//   MAS_Addr_Out        current micro-address (registered)
//   MAS_StackDepth_Out  return stack occupancy
//   MAS_Overflow_Out    sticky: call with stack full
//   MAS_Underflow_Out   sticky: return with stack empty
//   MAS_Wrap_Out        one-cycle pulse: increment wrapped to 0
module micro_addr_sequencer
  import mas_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 11,
  parameter int                    STACK_DEPTH = 4,
  parameter int                    COND_COUNT  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                             MAS_CLOCK_50,
  input  logic                             MAS_RESET_InLow,
  input  logic                             MAS_Enable_In,
  input  logic [2:0]                       MAS_Op_In,
  input  logic [ADDR_WIDTH-1:0]            MAS_Target_In,
  input  logic [$clog2(COND_COUNT)-1:0]    MAS_CondSel_In,
  input  logic                             MAS_CondPol_In,
  input  logic [COND_COUNT-1:0]            MAS_Cond_In,
  output logic [ADDR_WIDTH-1:0]            MAS_Addr_Out,
  output logic [depth_w(STACK_DEPTH)-1:0]  MAS_StackDepth_Out,
  output logic                             MAS_Overflow_Out,
  output logic                             MAS_Underflow_Out,
  output logic                             MAS_Wrap_Out
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ovf, r_unf, r_wrap;

  logic [ADDR_WIDTH-1:0] w_inc, w_next, w_top;
  logic                  w_take, w_push, w_pop, w_clr;
  logic                  w_wrap, w_set_ovf, w_set_unf;
  logic                  w_full, w_empty;

  assign w_inc = r_addr + 1'b1;

  // Out-of-range selects (non power-of-2 COND_COUNT) never take.
  always_comb begin
    w_take = 1'b0;
    if (int'(MAS_CondSel_In) < COND_COUNT)
      w_take = MAS_Cond_In[MAS_CondSel_In] ~^ MAS_CondPol_In;
  end

  always_comb begin
    w_next    = r_addr;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clr     = 1'b0;
    w_wrap    = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (MAS_Enable_In) begin
      unique case (MAS_Op_In)
        OP_INC: begin
          w_next = w_inc;
          w_wrap = &r_addr;
        end
        OP_JMP: w_next = MAS_Target_In;
        OP_BRC: begin
          w_next = w_take ? MAS_Target_In : w_inc;
          w_wrap = !w_take && (&r_addr);
        end
        OP_CALL, OP_CALLC: begin
          if (MAS_Op_In == OP_CALLC && !w_take) begin
            w_next = w_inc;
            w_wrap = &r_addr;
          end else if (w_full) begin
            w_set_ovf = 1'b1;          // address held, nothing pushed
          end else begin
            w_push = 1'b1;             // return value wraps silently
            w_next = MAS_Target_In;
          end
        end
        OP_RET: begin
          if (w_empty) w_set_unf = 1'b1;
          else begin
            w_pop  = 1'b1;
            w_next = w_top;
          end
        end
        OP_HOLD: w_next = r_addr;
        OP_RESTART: begin
          w_next = RESET_ADDR;
          w_clr  = 1'b1;
        end
        default: w_next = r_addr;
      endcase
    end
  end

  always_ff @(negedge MAS_CLOCK_50 or negedge MAS_RESET_InLow) begin
    if (!MAS_RESET_InLow) begin
      r_addr <= RESET_ADDR;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_addr <= w_next;
      r_wrap <= w_wrap;
      r_ovf  <= w_clr ? 1'b0 : (r_ovf | w_set_ovf);
      r_unf  <= w_clr ? 1'b0 : (r_unf | w_set_unf);
    end
  end

  mas_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .i_clk  (MAS_CLOCK_50),
    .i_rst_n(MAS_RESET_InLow),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clear(w_clr),
    .i_din  (w_inc),
    .o_dout (w_top),
    .o_depth(MAS_StackDepth_Out),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign MAS_Addr_Out      = r_addr;
  assign MAS_Overflow_Out  = r_ovf;
  assign MAS_Underflow_Out = r_unf;
  assign MAS_Wrap_Out      = r_wrap;

endmodule

// File: tb/tb_micro_addr_sequencer.sv
module tb_micro_addr_sequencer;
  import mas_pkg::*;

  logic        clk = 1'b1;
  logic        rst_n;
  logic        en;
  logic [2:0]  op;
  logic [10:0] tgt;
  logic [1:0]  sel;
  logic        pol;
  logic [3:0]  cond;
  logic [10:0] addr;
  logic [2:0]  depth;
  logic        ovf, unf, wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  micro_addr_sequencer #(
    .ADDR_WIDTH(11), .STACK_DEPTH(4), .COND_COUNT(4), .RESET_ADDR(11'h000)
  ) dut (
    .MAS_CLOCK_50      (clk),
    .MAS_RESET_InLow   (rst_n),
    .MAS_Enable_In     (en),
    .MAS_Op_In         (op),
    .MAS_Target_In     (tgt),
    .MAS_CondSel_In    (sel),
    .MAS_CondPol_In    (pol),
    .MAS_Cond_In       (cond),
    .MAS_Addr_Out      (addr),
    .MAS_StackDepth_Out(depth),
    .MAS_Overflow_Out  (ovf),
    .MAS_Underflow_Out (unf),
    .MAS_Wrap_Out      (wrap)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one microinstruction, let one falling edge pass, sample 1 ns later.
  task automatic step(input logic [2:0] o, input logic [10:0] t);
    op = o; tgt = t;
    @(negedge clk); #1;
  endtask

  task automatic st(input string tag, input logic [10:0] a, input logic [2:0] d,
                    input logic o, input logic u, input logic w);
    chk({tag, ".addr"},  16'(addr),  16'(a));
    chk({tag, ".depth"}, 16'(depth), 16'(d));
    chk({tag, ".ovf"},   16'(ovf),   16'(o));
    chk({tag, ".unf"},   16'(unf),   16'(u));
    chk({tag, ".wrap"},  16'(wrap),  16'(w));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; op = OP_INC; tgt = '0;
    sel = 2'd0; pol = 1'b1; cond = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    st("reset", 11'h000, 3'd0, 0, 0, 0);
    rst_n = 1'b1;

    step(OP_INC, 11'h0); chk("inc1", 16'(addr), 16'h001);
    step(OP_INC, 11'h0); chk("inc2", 16'(addr), 16'h002);
    step(OP_INC, 11'h0); st("inc3", 11'h003, 3'd0, 0, 0, 0);

    step(OP_JMP, 11'h7FE); chk("jmp7fe", 16'(addr), 16'h7FE);
    step(OP_INC, 11'h0);   st("inc7ff", 11'h7FF, 3'd0, 0, 0, 0);
    step(OP_INC, 11'h0);   st("wrap",   11'h000, 3'd0, 0, 0, 1);
    step(OP_INC, 11'h0);   st("wrapoff", 11'h001, 3'd0, 0, 0, 0);

    cond = 4'b0100; sel = 2'd2; pol = 1'b1;
    step(OP_BRC, 11'h155); chk("brc_taken", 16'(addr), 16'h155);
    pol = 1'b0;
    step(OP_BRC, 11'h155); chk("brc_not", 16'(addr), 16'h156);
    sel = 2'd1;  // flag clear, branch on clear
    step(OP_BRC, 11'h0AA); chk("brc_clr", 16'(addr), 16'h0AA);

    step(OP_JMP,  11'h010); chk("jmp010", 16'(addr), 16'h010);
    step(OP_CALL, 11'h100); st("call1", 11'h100, 3'd1, 0, 0, 0);
    step(OP_CALL, 11'h200); st("call2", 11'h200, 3'd2, 0, 0, 0);
    step(OP_RET,  11'h0);   st("ret1",  11'h101, 3'd1, 0, 0, 0);
    step(OP_RET,  11'h0);   st("ret2",  11'h011, 3'd0, 0, 0, 0);

    // Fill: pushes 0x012, 0x301, 0x302, 0x303.
    step(OP_CALL, 11'h300);
    step(OP_CALL, 11'h301);
    step(OP_CALL, 11'h302);
    step(OP_CALL, 11'h303); st("fill", 11'h303, 3'd4, 0, 0, 0);
    step(OP_CALL, 11'h3F0); st("ovf",  11'h303, 3'd4, 1, 0, 0);
    step(OP_RET, 11'h0); st("pop1", 11'h303, 3'd3, 1, 0, 0);
    step(OP_RET, 11'h0); st("pop2", 11'h302, 3'd2, 1, 0, 0);
    step(OP_RET, 11'h0); st("pop3", 11'h301, 3'd1, 1, 0, 0);
    step(OP_RET, 11'h0); st("pop4", 11'h012, 3'd0, 1, 0, 0);
    step(OP_RET, 11'h0); st("unf",  11'h012, 3'd0, 1, 1, 0);
    step(OP_RESTART, 11'h0); st("restart", 11'h000, 3'd0, 0, 0, 0);

    sel = 2'd2; pol = 1'b0;  // bit 2 set -> not taken
    step(OP_CALLC, 11'h0AB); st("callc_not", 11'h001, 3'd0, 0, 0, 0);
    pol = 1'b1;
    step(OP_CALLC, 11'h0AB); st("callc_tk", 11'h0AB, 3'd1, 0, 0, 0);
    step(OP_HOLD, 11'h000);  st("hold", 11'h0AB, 3'd1, 0, 0, 0);

    step(OP_JMP,  11'h7FF);
    step(OP_CALL, 11'h050); st("call7ff", 11'h050, 3'd2, 0, 0, 0);
    step(OP_RET,  11'h0);   st("ret0",    11'h000, 3'd1, 0, 0, 0);
    step(OP_RET,  11'h0);   chk("ret_callc", 16'(addr), 16'h002);

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(OP_JMP, 11'h3AA); st("dis", 11'h002, 3'd0, 0, 0, 0);
    end
    en = 1'b1;

    step(OP_CALL, 11'h123);
    step(OP_CALL, 11'h124); chk("pre_rst_depth", 16'(depth), 16'd2);
    rst_n = 1'b0;
    #2;  // no clock edge in between
    st("async_rst", 11'h000, 3'd0, 0, 0, 0);
    #1 rst_n = 1'b1;
    step(OP_INC, 11'h0); st("post_rst", 11'h001, 3'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/micro_addr_sequencer.md
Name: micro_addr_sequencer

Overview:
- Parametrised next-generation micro-address unit for the microprogrammed datapath; replaces the plain "address + 1" incrementer.
- Holds the current micro-address register and computes the next address each cycle: increment, jump, conditional branch, call/return through a return-address stack, hold, soft restart.
- Drives the control-store address bus; opcode, target and condition select come from the current microinstruction word.

Parameters:
- ADDR_WIDTH, 11, width of micro-address and target.
- STACK_DEPTH, 4, return-address stack entries (>=1).
- COND_COUNT, 4, number of condition flag inputs (>=2).
- RESET_ADDR, 0, address loaded on reset and on soft restart.

Ports:
- MAS_CLOCK_50  in  1  system clock; state updates on falling edge.
- MAS_RESET_InLow  in  1  asynchronous active-low reset.
- MAS_Enable_In  in  1  advance enable; low = full hold.
- MAS_Op_In  in  3  next-address opcode.
- MAS_Target_In  in  ADDR_WIDTH  jump/branch/call target.
- MAS_CondSel_In  in  $clog2(COND_COUNT)  condition flag index.
- MAS_CondPol_In  in  1  1 = branch on flag set, 0 = branch on flag clear.
- MAS_Cond_In  in  COND_COUNT  datapath status flags.
- MAS_Addr_Out  out  ADDR_WIDTH  current micro-address (registered).
- MAS_StackDepth_Out  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- MAS_Overflow_Out  out  1  sticky: call attempted with stack full.
- MAS_Underflow_Out  out  1  sticky: return attempted with stack empty.
- MAS_Wrap_Out  out  1  one-cycle pulse: increment wrapped max to 0.

Behaviour:
- Reset (asynchronous, while MAS_RESET_InLow = 0):
  - Addr = RESET_ADDR, stack depth = 0.
  - Overflow = 0, Underflow = 0, Wrap = 0.
  - Stack contents don't-care.
- Sequential updates occur on the falling edge of MAS_CLOCK_50.
- Latency: the next address appears on MAS_Addr_Out one falling edge after op/target/cond are sampled.
- Condition: take = MAS_Cond_In[MAS_CondSel_In] XNOR MAS_CondPol_In.
- Increment is modulo 2^ADDR_WIDTH; inc = Addr + 1.
- Opcodes:
  - 000 INC: Addr <= inc.
  - 001 JMP: Addr <= Target.
  - 010 BRC: Addr <= take ? Target : inc.
  - 011 CALL: push inc; Addr <= Target.
  - 100 RET: Addr <= pop.
  - 101 HOLD: Addr unchanged.
  - 110 CALLC: if take, behaves as CALL; otherwise Addr <= inc.
  - 111 RESTART: Addr <= RESET_ADDR; depth <= 0; Overflow and Underflow cleared.
- Wrap: pulses high for exactly one cycle when the next address is taken from inc and Addr = all-ones. Applies to INC, BRC not-taken and CALLC not-taken. The pushed return value of CALL at all-ones is 0 and does not assert Wrap.
- Stack full (depth = STACK_DEPTH) on CALL or taken CALLC:
  - No push, no jump, Addr held.
  - Overflow set.
- Stack empty on RET:
  - Addr held.
  - Underflow set.
- Sticky flags clear only on reset or RESTART.
- MAS_Enable_In = 0:
  - Addr, stack and sticky flags hold.
  - Wrap = 0.
  - Op is ignored.
- Out-of-range CondSel (COND_COUNT not a power of 2): take = 0.
- Reset asserted mid-operation overrides everything immediately. First update after release is on the first falling edge with reset high.

Decomposition:
- Package mas_pkg holds:
  - opcode localparams (OP_INC..OP_RESTART);
  - function for stack-depth width.
- Sub-module mas_stack: LIFO of STACK_DEPTH x ADDR_WIDTH.
  - Inputs: push, pop, clear, din.
  - Outputs: dout (top entry, combinational), depth, full, empty.
  - Same clock edge and reset as the parent.
- The parent holds the address register, condition mux, opcode decode and flag logic.

Test Plan:
- Reset, then INC x3 -> Addr 0,1,2,3; depth 0; all flags 0.
- Addr = 0x7FE, INC x2 -> 0x7FF then 0x000; Wrap high exactly one cycle on the second step.
- Cond = 4'b0100, CondSel = 2, Pol = 1, BRC Target = 0x155 -> Addr 0x155. Same with Pol = 0 -> Addr = previous + 1.
- Nested calls:
  - From Addr 0x010: CALL 0x100 -> Addr 0x100, depth 1.
  - From 0x100: CALL 0x200 -> Addr 0x200, depth 2.
  - RET -> Addr 0x101, depth 1; RET -> Addr 0x011, depth 0.
- Stack limits:
  - 4 calls fill the stack; a 5th CALL -> Addr unchanged, Overflow = 1, depth 4.
  - 5 RETs: the 5th -> Underflow = 1, Addr held.
  - RESTART -> Addr 0, both flags 0.
- Control edge cases:
  - Enable = 0 with op JMP 0x3AA -> Addr unchanged for all disabled cycles.
  - Assert reset mid-run (depth 2) -> Addr = RESET_ADDR and depth 0 without waiting for a clock edge.
